correlator_scan_ctrl: RTL

//  Sequences one full-frame template-correlation pass over the static frame BRAM.

---
 rtl/correlator_pkg.sv | 10 +
 rtl/correlator_scan_ctrl_if.sv | 30 +++
 rtl/correlator_scan_ctrl_rd_delay_line.sv | 43 ++++
 rtl/correlator_scan_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/correlator_pkg.sv
// Shared constants and types for the template-correlation scan controller.
package correlator_pkg;
    localparam int VGA_WIDTH     = 640;
    localparam int VGA_HEIGHT    = 480;
    localparam int TEMPLATE_SIZE = 3;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} scan_state_t;
endpackage

// File: rtl/correlator_scan_ctrl_if.sv
// Control/status bundle between the scan controller and the BRAM/correlator datapath.
interface correlator_scan_ctrl_if #(parameter int ADDR_W = 19);
    import correlator_pkg::*;

    logic              frame_rdy;
    logic              abort;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              pix_valid;
    coord_t            pix_x;
    coord_t            pix_y;
    logic              win_valid;
    coord_t            win_x;
    coord_t            win_y;
    logic              busy;
    logic              done;
    logic [7:0]        frame_cnt;

    modport master (
        input  frame_rdy, abort,
        output rd_addr, rd_en, pix_valid, pix_x, pix_y,
               win_valid, win_x, win_y, busy, done, frame_cnt
    );

    modport slave (
        output frame_rdy, abort,
        input  rd_addr, rd_en, pix_valid, pix_x, pix_y,
               win_valid, win_x, win_y, busy, done, frame_cnt
    );
endinterface

// File: rtl/correlator_scan_ctrl_rd_delay_line.sv
// Matches the BRAM read latency: {valid,x,y} pass through DEPTH register stages.
// A synchronous flush squashes every in-flight valid bit.
module rd_delay_line
    import correlator_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   in_valid,
    input  coord_t in_x,
    input  coord_t in_y,
    output logic   out_valid,
    output coord_t out_x,
    output coord_t out_y
);
    logic [DEPTH-1:0]      vld;
    logic [DEPTH-1:0][9:0] xs;
    logic [DEPTH-1:0][9:0] ys;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            xs  <= '0;
            ys  <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld[i] <= vld[i-1];
                xs[i]  <= xs[i-1];
                ys[i]  <= ys[i-1];
            end
            vld[0] <= in_valid;
            xs[0]  <= in_x;
            ys[0]  <= in_y;
            if (flush) vld <= '0;
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_x     = xs[DEPTH-1];
    assign out_y     = ys[DEPTH-1];
endmodule

// File: rtl/correlator_scan_ctrl.sv
// Full-frame raster scan of the static frame BRAM: issues reads, realigns pixel
// coordinates to the read latency, and flags windows fully inside the image.
module correlator_scan_ctrl
    import correlator_pkg::*;
#(
    parameter int IMG_W  = VGA_WIDTH,
    parameter int IMG_H  = VGA_HEIGHT,
    parameter int TPL    = TEMPLATE_SIZE,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 19
) (
    input  logic clk,
    input  logic rst_n,
    correlator_scan_ctrl_if.master bus
);
    localparam int                NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam coord_t            X_MAX     = coord_t'(IMG_W - 1);
    localparam coord_t            EDGE      = coord_t'(TPL - 1);
    localparam int                CNT_W     = $clog2(RD_LAT + 1);

    scan_state_t       state, nstate;
    logic              frame_rdy_q, start;
    logic              rd_en, done, flush, restart;
    logic [ADDR_W-1:0] rd_addr;
    coord_t            rx, ry;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        frame_cnt;
    logic              pix_v, win_v;
    coord_t            pix_x, pix_y;

    assign start = bus.frame_rdy & ~frame_rdy_q;

    // Abort has priority over a start edge; the edge is consumed either way.
    always_comb begin
        nstate  = state;
        rd_en   = 1'b0;
        done    = 1'b0;
        flush   = 1'b0;
        restart = 1'b0;
        case (state)
            IDLE: begin
                if (start && !bus.abort) begin
                    nstate  = SCAN;
                    restart = 1'b1;
                end
            end
            SCAN, DRAIN: begin
                rd_en = (state == SCAN);
                if (bus.abort) begin
                    nstate = IDLE;
                    flush  = 1'b1;
                end else if (start) begin
                    nstate  = SCAN;
                    flush   = 1'b1;
                    restart = 1'b1;
                end else if (state == SCAN) begin
                    if (rd_addr == LAST_ADDR) nstate = DRAIN;
                end else if (cnt == '0) begin
                    done   = 1'b1;
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame_rdy_q <= 1'b0;
            rd_addr     <= '0;
            rx          <= '0;
            ry          <= '0;
            cnt         <= '0;
            frame_cnt   <= '0;
        end else begin
            state       <= nstate;
            frame_rdy_q <= bus.frame_rdy;
            if (restart) begin
                rd_addr <= '0;
                rx      <= '0;
                ry      <= '0;
            end else if (state == SCAN && nstate == SCAN) begin
                rd_addr <= rd_addr + 1'b1;
                if (rx == X_MAX) begin
                    rx <= '0;
                    ry <= ry + 1'b1;
                end else begin
                    rx <= rx + 1'b1;
                end
            end
            // Counter lands on 0 exactly when the last pixel leaves the delay line.
            if (state == SCAN && nstate == DRAIN) cnt <= CNT_W'(RD_LAT - 1);
            else if (state == DRAIN && cnt != '0) cnt <= cnt - 1'b1;
            if (done) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    rd_delay_line #(.DEPTH(RD_LAT)) u_dly (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (rd_en),
        .in_x     (rx),
        .in_y     (ry),
        .out_valid(pix_v),
        .out_x    (pix_x),
        .out_y    (pix_y)
    );

    // Subtraction only when the window is inside the image, so no underflow.
    assign win_v = pix_v && (pix_x >= EDGE) && (pix_y >= EDGE);

    assign bus.rd_addr   = rd_addr;
    assign bus.rd_en     = rd_en;
    assign bus.pix_valid = pix_v;
    assign bus.pix_x     = pix_x;
    assign bus.pix_y     = pix_y;
    assign bus.win_valid = win_v;
    assign bus.win_x     = win_v ? pix_x - EDGE : '0;
    assign bus.win_y     = win_v ? pix_y - EDGE : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done;
    assign bus.frame_cnt = frame_cnt;
endmodule
